// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath front-end: FSM state encodings
// and default widths used by the operand loader.
package alu_pkg;

  // Default operand width feeding the 16-bit 2:1 selector.
  localparam int DEFAULT_WIDTH = 16;

  // Default width of the consumed-set counter.
  localparam int DEFAULT_CNT_W = 8;

  // Operand loader FSM encodings.
  typedef enum logic [1:0] {
    ST_LOAD_X  = 2'd0,
    ST_LOAD_Y  = 2'd1,
    ST_LOAD_S  = 2'd2,
    ST_PRESENT = 2'd3
  } state_e;

  // True in the states that take a word from the serial input bus.
  function automatic logic is_load_state(input state_e st);
    return (st != ST_PRESENT);
  endfunction

endpackage : alu_pkg

// File: rtl/wrap_counter.sv
// Free-running event counter that wraps from all-ones back to zero with no
// saturation or overflow indication.
module wrap_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: step by one on each increment request, wrap naturally.
  always_comb begin
    // NOTE: assign a default before any condition so no path leaves count_d
    // unassigned, which would otherwise infer a latch.
    count_d = count_q;
    if (inc) begin
      count_d = count_q + ONE;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : wrap_counter

// File: rtl/operand_loader.sv
// Operand loader: assembles a serial stream of X, Y and select words into one
// stable operand set for the 2:1 selector, presented with valid/ready, and
// counts consumed sets.
module operand_loader
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Y,
  output logic             S,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] txn_count
);

  state_e           state_q;
  state_e           state_d;

  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] x_d;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y_d;
  logic             s_q;
  logic             s_d;
  logic             out_valid_q;
  logic             out_valid_d;

  logic             accept;
  logic             consume;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD_X;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of process evaluation order.
      state_q <= state_d;
    end
  end

  // Next-state logic: abort overrides everything, otherwise step through
  // the three load states on accepted words and leave PRESENT on consume.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_LOAD_X;
    end else begin
      case (state_q)
        ST_LOAD_X:  if (din_valid) state_d = ST_LOAD_Y;
        ST_LOAD_Y:  if (din_valid) state_d = ST_LOAD_S;
        ST_LOAD_S:  if (din_valid) state_d = ST_PRESENT;
        ST_PRESENT: if (out_ready) state_d = ST_LOAD_X;
        default:                   state_d = ST_LOAD_X;
      endcase
    end
  end

  // Output decode: input-side ready from state only, plus the qualified
  // accept and consume strobes (both suppressed by abort).
  always_comb begin
    din_ready = is_load_state(state_q);
    accept    = din_valid && din_ready && !abort;
    consume   = (state_q == ST_PRESENT) && out_ready && !abort;
  end

  // Operand capture: the current load state selects which holding register
  // takes the accepted word; only bit 0 of the select word is kept.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    s_d = s_q;
    if (accept) begin
      case (state_q)
        ST_LOAD_X: x_d = din;
        ST_LOAD_Y: y_d = din;
        ST_LOAD_S: s_d = din[0];
        default:   ;
      endcase
    end
    out_valid_d = (state_d == ST_PRESENT);
  end

  // Operand and valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand holding registers are reset as well because they
      // drive the selector directly and must show a known zero set at reset.
      x_q         <= '0;
      y_q         <= '0;
      s_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Consumed-set counter.
  wrap_counter #(
    .CNT_W (CNT_W)
  ) u_txn_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (consume),
    .count (txn_count)
  );

  assign X         = x_q;
  assign Y         = y_q;
  assign S         = s_q;
  assign out_valid = out_valid_q;

endmodule : operand_loader

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader. Two instances share one stimulus
// stream: the default 8-bit counter and a 2-bit counter for wrap behaviour.
module tb_operand_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;

  logic        din_ready;
  logic [15:0] x, y;
  logic        s;
  logic        out_valid;
  logic [7:0]  txn_count;

  logic        din_ready_b;
  logic [15:0] x_b, y_b;
  logic        s_b;
  logic        out_valid_b;
  logic [1:0]  txn_count_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pres_cnt = 0;
  bit pres_en = 1'b0;

  operand_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .abort     (abort),
    .X         (x),
    .Y         (y),
    .S         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .txn_count (txn_count)
  );

  operand_loader #(.WIDTH(16), .CNT_W(2)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready_b),
    .abort     (abort),
    .X         (x_b),
    .Y         (y_b),
    .S         (s_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .txn_count (txn_count_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: a count of words gathered so far (3 means a full set
  // is on offer), the gathered values and the total number of consumed sets.
  int          m_words = 0;
  logic [15:0] m_x = '0;
  logic [15:0] m_y = '0;
  logic        m_s = 1'b0;
  int          m_consumed = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_words    = 0;
      m_x        = '0;
      m_y        = '0;
      m_s        = 1'b0;
      m_consumed = 0;
    end else if (abort) begin
      m_words = 0;
    end else if (m_words == 3) begin
      if (out_ready) begin
        m_words = 0;
        m_consumed++;
      end
    end else if (din_valid) begin
      if (m_words == 0) m_x = din;
      else if (m_words == 1) m_y = din;
      else m_s = din[0];
      m_words++;
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    check("x", {16'h0, x}, {16'h0, m_x});
    check("y", {16'h0, y}, {16'h0, m_y});
    check("s", {31'h0, s}, {31'h0, m_s});
    check("out_valid", {31'h0, out_valid}, (m_words == 3) ? 32'd1 : 32'd0);
    check("din_ready", {31'h0, din_ready}, (m_words < 3) ? 32'd1 : 32'd0);
    check("txn_count", {24'h0, txn_count}, m_consumed % 256);
    check("x_b", {16'h0, x_b}, {16'h0, m_x});
    check("out_valid_b", {31'h0, out_valid_b}, (m_words == 3) ? 32'd1 : 32'd0);
    check("txn_count_b", {30'h0, txn_count_b}, m_consumed % 4);
    if (pres_en && out_valid) pres_cnt++;
  end

  // Offer one word and hold it until the edge that accepts it.
  task automatic send_word(input logic [15:0] w);
    int budget;
    budget    = 0;
    din       = w;
    din_valid = 1'b1;
    while (din_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("send_accept", (budget < 50) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic consume_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int start;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_x", {16'h0, x}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_din_ready", {31'h0, din_ready}, 32'd1);
    check("rst_txn", {24'h0, txn_count}, 32'd0);
    rst_n = 1'b1;

    // Load and hold with out_ready low; offered words must be ignored.
    send_word(16'h0000);
    send_word(16'hFF00);
    send_word(16'h0001);
    check("t1_x", {16'h0, x}, 32'h0000);
    check("t1_y", {16'h0, y}, 32'hFF00);
    check("t1_s", {31'h0, s}, 32'd1);
    check("t1_out_valid", {31'h0, out_valid}, 32'd1);
    check("t1_din_ready", {31'h0, din_ready}, 32'd0);
    din = 16'hBEEF;
    din_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t1_hold_y", {16'h0, y}, 32'hFF00);
      check("t1_hold_valid", {31'h0, out_valid}, 32'd1);
    end
    din_valid = 1'b0;
    consume_one();
    check("t1_consumed_valid", {31'h0, out_valid}, 32'd0);
    check("t1_txn", {24'h0, txn_count}, 32'd1);
    check("t1_din_ready", {31'h0, din_ready}, 32'd1);

    // Gapped input; S keeps only bit 0 of 0xFFFE.
    send_word(16'h1234);
    din = 16'hDEAD;
    @(negedge clk);
    send_word(16'hABCD);
    @(negedge clk);
    send_word(16'hFFFE);
    check("t2_x", {16'h0, x}, 32'h1234);
    check("t2_y", {16'h0, y}, 32'hABCD);
    check("t2_s", {31'h0, s}, 32'd0);
    check("t2_out_valid", {31'h0, out_valid}, 32'd1);
    din = 16'h7777;
    din_valid = 1'b1;
    repeat (2) @(negedge clk);
    din_valid = 1'b0;
    check("t2_no_extra", {16'h0, x}, 32'h1234);
    consume_one();
    check("t2_txn", {24'h0, txn_count}, 32'd2);
    check("t2_txn_b", {30'h0, txn_count_b}, 32'd2);

    // Back-to-back sets with out_ready tied high: 4 cycles per set.
    out_ready = 1'b1;
    start = cyc;
    pres_cnt = 0;
    pres_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_word(16'(16'h1000 + k));
      send_word(16'(16'h2000 + k));
      send_word(16'(16'h0002 + k));
    end
    @(negedge clk);
    pres_en = 1'b0;
    out_ready = 1'b0;
    check("t3_cycles", cyc - start, 32'd12);
    check("t3_present_cycles", pres_cnt, 32'd3);
    check("t3_txn", {24'h0, txn_count}, 32'd5);
    check("t3_txn_b_wrapped", {30'h0, txn_count_b}, 32'd1);

    // Abort after the Y word; the word offered with abort is dropped.
    send_word(16'h00FF);
    send_word(16'h0F0F);
    din = 16'h1111;
    din_valid = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    din_valid = 1'b0;
    check("t4_din_ready", {31'h0, din_ready}, 32'd1);
    check("t4_x_kept", {16'h0, x}, 32'h00FF);
    check("t4_y_kept", {16'h0, y}, 32'h0F0F);
    check("t4_txn", {24'h0, txn_count}, 32'd5);
    send_word(16'hAAAA);
    send_word(16'h5555);
    send_word(16'h0001);
    check("t4_x", {16'h0, x}, 32'hAAAA);
    check("t4_y", {16'h0, y}, 32'h5555);
    check("t4_s", {31'h0, s}, 32'd1);
    check("t4_out_valid", {31'h0, out_valid}, 32'd1);
    consume_one();
    check("t4_txn_after", {24'h0, txn_count}, 32'd6);

    // Abort and out_ready together in PRESENT: abort wins.
    send_word(16'h0102);
    send_word(16'h0304);
    send_word(16'h0005);
    abort = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    out_ready = 1'b0;
    check("t5_out_valid", {31'h0, out_valid}, 32'd0);
    check("t5_txn", {24'h0, txn_count}, 32'd6);
    check("t5_x_kept", {16'h0, x}, 32'h0102);

    // Asynchronous reset while waiting for the select word.
    send_word(16'h4444);
    send_word(16'h5555);
    din = 16'h0001;
    din_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("t6_x", {16'h0, x}, 32'h0);
    check("t6_y", {16'h0, y}, 32'h0);
    check("t6_s", {31'h0, s}, 32'd0);
    check("t6_out_valid", {31'h0, out_valid}, 32'd0);
    check("t6_din_ready", {31'h0, din_ready}, 32'd1);
    check("t6_txn", {24'h0, txn_count}, 32'd0);
    check("t6_txn_b", {30'h0, txn_count_b}, 32'd0);
    din_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Recovery after reset.
    send_word(16'h0F00);
    send_word(16'h00F0);
    send_word(16'h0001);
    check("t7_y", {16'h0, y}, 32'h00F0);
    consume_one();
    check("t7_txn", {24'h0, txn_count}, 32'd1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_operand_loader

// File: doc/operand_loader.md
# operand_loader

Upstream feeder for the 16-bit 2:1 selector (`mux_2to1`) in the ALU datapath. It accepts a serial stream of words on a single input bus (X operand, then Y operand, then a select word), assembles them into one stable operand set, and presents X, Y and S in parallel with a valid/ready handshake. The held values drive the selector's X/Y/S inputs directly. A wrapping counter records how many operand sets have been consumed.

## Interface
- `WIDTH`, 16, operand width in bits (X, Y, din).
- `CNT_W`, 8, width of the transaction counter.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `din`  in  WIDTH  serial input word.
- `din_valid`  in  1  `din` carries a word this cycle.
- `din_ready`  out  1  block accepts `din` this cycle.
- `abort`  in  1  synchronous discard of the partially or fully assembled set.
- `X`  out  WIDTH  held X operand.
- `Y`  out  WIDTH  held Y operand.
- `S`  out  1  held select; equals bit 0 of the third word.
- `out_valid`  out  1  X/Y/S form a complete set.
- `out_ready`  in  1  downstream consumes the set this cycle.
- `txn_count`  out  CNT_W  number of consumed sets, modulo 2^CNT_W.

## Operation
- FSM states: `LOAD_X`, `LOAD_Y`, `LOAD_S`, `PRESENT`.
- Input handshake: a word is accepted when `din_valid && din_ready`. `din_ready` is 1 in all three LOAD states and 0 in `PRESENT`. It is decoded combinationally from the state only.
- Word acceptance by state:
  - `LOAD_X`: accept -> X <= din; go to `LOAD_Y`.
  - `LOAD_Y`: accept -> Y <= din; go to `LOAD_S`.
  - `LOAD_S`: accept -> S <= din[0]; go to `PRESENT`. din[WIDTH-1:1] are ignored.
- In `PRESENT`: `out_valid`=1, and X/Y/S are held stable.
  - `out_ready`=1 -> go to `LOAD_X` and increment `txn_count`.
- `txn_count` wraps from 2^CNT_W-1 to 0 with no saturation or flag.
- `abort` has the highest priority, in any state:
  - next state is `LOAD_X` and `out_valid` goes to 0;
  - X/Y/S keep their last values and `txn_count` does not change;
  - a word offered in the same cycle is not captured.
- `abort` and `out_ready` in the same `PRESENT` cycle -> the abort wins and the count does not increment.
- Outside LOAD states `din_valid` is ignored, and no word is lost because `din_ready`=0.
- Reset mid-transaction discards the partial set immediately.

## Timing
- Reset values (async, applied while `rst_n`=0):
  - state `LOAD_X`, X=0, Y=0, S=0, `out_valid`=0, `txn_count`=0;
  - `din_ready`=1 because it is decoded from state `LOAD_X`.
- All outputs except `din_ready` are registered.
- Latency: `out_valid` rises on the clock edge that accepts the third word, so it is visible in the following cycle.
- `out_valid` falls on the edge where `out_ready`=1 is sampled in `PRESENT`. `din_ready` rises in the same following cycle.
- Minimum throughput is 4 cycles per set: 3 load cycles plus 1 present cycle. The X word of the next set is never accepted in the consume cycle.
- Stalls: gaps in `din_valid` hold the state indefinitely. `out_ready`=0 holds `PRESENT` indefinitely with outputs constant.
- Release of `rst_n` is assumed synchronised externally. The first accept can occur on the first rising edge after deassertion.

## Structure
- Shared package `alu_pkg`:
  - 2-bit state encodings `ST_LOAD_X`=0, `ST_LOAD_Y`=1, `ST_LOAD_S`=2, `ST_PRESENT`=3;
  - default `WIDTH` constant 16.
- Sub-module `wrap_counter` (parameter `CNT_W`, inputs `clk`, `rst_n`, `inc`; output `count`) implements `txn_count`.
- X/Y/S registers and the FSM live in the top module.

## Test plan
- Reset then load: din 0x0000, 0xFF00, 0x0001 on 3 consecutive valid cycles, `out_ready`=0 -> next cycle X=0x0000, Y=0xFF00, S=1, `out_valid`=1, `din_ready`=0, held for 5 cycles. Then `out_ready`=1 -> `out_valid`=0, `txn_count`=1.
- Gapped input: `din_valid` toggles 1/0 for words 0x1234, 0xABCD, 0xFFFE -> S=0 (bit 0 only), `out_valid` after the 3rd accept, no extra words captured.
- Back-to-back: 3 consecutive sets with `out_ready` tied to 1 -> each set is presented exactly 1 cycle, 4 cycles per set, `txn_count`=3.
- Abort after Y word (X=0x00FF, Y=0x0F0F) -> state `LOAD_X`, `txn_count` unchanged. A new set 0xAAAA, 0x5555, 0x0001 presents correctly.
- Abort and `out_ready` together in `PRESENT` -> `out_valid`=0, no increment. Also assert `rst_n`=0 mid-`LOAD_S` -> all outputs return to reset values asynchronously.
- Counter wrap with `CNT_W`=2 -> after 4 consumed sets `txn_count`=0.
